// File: rtl/miss_request_queue_if.sv
// Miss/memory/fill handshake bundle for miss_request_queue.
// The slave modport is the queue; the master is the cache and memory side.
interface miss_request_queue_if #(
  parameter int ADDR_BITS   = 32,
  parameter int BLOCK_WIDTH = 256,
  parameter int DEPTH       = 4
);
  logic                         miss_valid;
  logic [ADDR_BITS-1:0]         miss_address;
  logic                         miss_ready;
  logic                         miss_merged;
  logic                         mem_req_valid;
  logic                         mem_req_ready;
  logic [ADDR_BITS-1:0]         mem_req_address;
  logic                         mem_resp_valid;
  logic [BLOCK_WIDTH-1:0]       mem_resp_data;
  logic                         fill_valid;
  logic [ADDR_BITS-1:0]         fill_address;
  logic [BLOCK_WIDTH-1:0]       fill_data;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         busy;

  modport master (
    output miss_valid, miss_address, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  miss_ready, miss_merged, mem_req_valid, mem_req_address,
    input  fill_valid, fill_address, fill_data, count, busy
  );

  modport slave (
    input  miss_valid, miss_address, mem_req_ready, mem_resp_valid, mem_resp_data,
    output miss_ready, miss_merged, mem_req_valid, mem_req_address,
    output fill_valid, fill_address, fill_data, count, busy
  );
endinterface

// File: rtl/miss_request_queue.sv
// Outstanding block-miss FIFO issuing one fetch at a time and a one-cycle fill pulse.
// Define MRQ_MERGE_EN to merge secondary misses into pending entries.
module miss_request_queue #(
  parameter int ADDR_BITS      = 32,
  parameter int BLOCK_ID_START = 5,
  parameter int BLOCK_WIDTH    = 256,
  parameter int DEPTH          = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  miss_request_queue_if.slave  bus
);
  localparam int IDW = ADDR_BITS - BLOCK_ID_START;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

  state_t                 state_q;
  logic [IDW-1:0]         blk_q [DEPTH];
  logic [DEPTH-1:0]       vld_q;
  logic [PW-1:0]          head_q, tail_q;
  logic [CW-1:0]          count_q, count_d;
  logic                   mem_req_valid_q;
  logic [ADDR_BITS-1:0]   mem_req_address_q;
  logic                   fill_valid_q;
  logic [ADDR_BITS-1:0]   fill_address_q;
  logic [BLOCK_WIDTH-1:0] fill_data_q;

  logic [IDW-1:0]         miss_blk;
  logic                   merge_hit, push, pop;
  logic [PW-1:0]          head_nx;
  logic [IDW-1:0]         next_blk;
  logic [ADDR_BITS-1:0]   head_addr, next_addr;

  assign miss_blk = bus.miss_address[ADDR_BITS-1:BLOCK_ID_START];
  wire unused_offset = ^bus.miss_address[BLOCK_ID_START-1:0];

`ifdef MRQ_MERGE_EN
  // The head being filled this cycle is about to retire, so it cannot absorb a miss.
  always_comb begin
    merge_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && blk_q[i] == miss_blk && !(state_q == FILL && PW'(i) == head_q))
        merge_hit = 1'b1;
    end
  end
`else
  assign merge_hit = 1'b0;
  wire unused_vld = ^vld_q;
`endif

  assign push = bus.miss_valid & ~merge_hit & (count_q != CW'(DEPTH));
  assign pop  = (state_q == FILL);

  assign bus.miss_ready  = bus.miss_valid & (merge_hit | (count_q != CW'(DEPTH)));
  assign bus.miss_merged = bus.miss_valid & merge_hit;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // A miss pushed during FILL into a one-entry queue lands exactly at the new head.
  assign head_nx   = head_q + 1'b1;
  assign next_blk  = (push && tail_q == head_nx) ? miss_blk : blk_q[head_nx];
  assign head_addr = {blk_q[head_q], {BLOCK_ID_START{1'b0}}};
  assign next_addr = {next_blk, {BLOCK_ID_START{1'b0}}};

  always_ff @(posedge clk) begin
    if (push) blk_q[tail_q] <= miss_blk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_nx;
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      mem_req_valid_q   <= 1'b0;
      mem_req_address_q <= '0;
      fill_valid_q      <= 1'b0;
      fill_address_q    <= '0;
      fill_data_q       <= '0;
    end else begin
      fill_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (count_q != '0) begin
          state_q           <= REQ;
          mem_req_valid_q   <= 1'b1;
          mem_req_address_q <= head_addr;
        end
        REQ: if (bus.mem_req_ready) begin
          state_q         <= WAIT;
          mem_req_valid_q <= 1'b0;
        end
        WAIT: if (bus.mem_resp_valid) begin
          state_q        <= FILL;
          fill_valid_q   <= 1'b1;
          fill_address_q <= head_addr;
          fill_data_q    <= bus.mem_resp_data;
        end
        FILL: if (count_d != '0) begin
          state_q           <= REQ;
          mem_req_valid_q   <= 1'b1;
          mem_req_address_q <= next_addr;
        end else begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req_valid   = mem_req_valid_q;
  assign bus.mem_req_address = mem_req_address_q;
  assign bus.fill_valid      = fill_valid_q;
  assign bus.fill_address    = fill_address_q;
  assign bus.fill_data       = fill_data_q;
  assign bus.count           = count_q;
  assign bus.busy            = (count_q != '0);
endmodule

// File: tb/tb_miss_request_queue.sv
// Directed bench for miss_request_queue; expectations follow MRQ_MERGE_EN if defined.
module tb_miss_request_queue;
  localparam int AB = 32;
  localparam int BW = 256;
  localparam int DEPTH = 4;
`ifdef MRQ_MERGE_EN
  localparam logic MERGE = 1'b1;
`else
  localparam logic MERGE = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   nreq = 0;
  int   nfill = 0;
  int   req0, fill0;

  miss_request_queue_if #(.ADDR_BITS(AB), .BLOCK_WIDTH(BW), .DEPTH(DEPTH)) bus ();

  miss_request_queue #(
    .ADDR_BITS(AB), .BLOCK_ID_START(5), .BLOCK_WIDTH(BW), .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_req_valid && bus.mem_req_ready) nreq++;
      if (bus.fill_valid) nfill++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grants the pending request, answers it, and returns in the FILL cycle.
  task automatic serve(input logic [AB-1:0] a);
    logic [BW-1:0] d;
    d = {8{a}};
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 20 && bus.mem_req_valid !== 1'b1; i++) tick();
    chk("serve_req_valid", bus.mem_req_valid, 1);
    chk("serve_req_addr", bus.mem_req_address, a);
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = d;
    tick();
    bus.mem_resp_valid = 1'b0;
    chk("serve_fill_valid", bus.fill_valid, 1);
    chk("serve_fill_addr", bus.fill_address, a);
    chk("serve_fill_data", bus.fill_data, d);
  endtask

  task automatic miss(input logic [AB-1:0] a);
    bus.miss_valid   = 1'b1;
    bus.miss_address = a;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.miss_valid = 1'b0;
    bus.miss_address = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = '0;
    tick();
    tick();

    // Reset values
    chk("rst_count", bus.count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_req_valid", bus.mem_req_valid, 0);
    chk("rst_req_addr", bus.mem_req_address, 0);
    chk("rst_fill_valid", bus.fill_valid, 0);
    chk("rst_fill_addr", bus.fill_address, 0);
    chk("rst_fill_data", bus.fill_data, 0);
    chk("rst_miss_ready", bus.miss_ready, 0);
    chk("rst_miss_merged", bus.miss_merged, 0);
    rst = 1'b0;

    // Single miss
    bus.mem_req_ready = 1'b1;
    miss(32'h0000_1234);
    chk("single_ready", bus.miss_ready, 1);
    chk("single_merged", bus.miss_merged, 0);
    tick();
    bus.miss_valid = 1'b0;
    chk("single_count1", bus.count, 1);
    chk("single_busy", bus.busy, 1);
    chk("single_req_early", bus.mem_req_valid, 0);
    tick();
    chk("single_req_valid", bus.mem_req_valid, 1);
    chk("single_req_addr", bus.mem_req_address, 32'h0000_1220);
    tick();
    bus.mem_req_ready = 1'b0;
    chk("single_req_drop", bus.mem_req_valid, 0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = {32{8'hAA}};
    tick();
    bus.mem_resp_valid = 1'b0;
    chk("single_fill_valid", bus.fill_valid, 1);
    chk("single_fill_addr", bus.fill_address, 32'h0000_1220);
    chk("single_fill_data", bus.fill_data, {32{8'hAA}});
    chk("single_count_fill", bus.count, 1);
    tick();
    chk("single_fill_once", bus.fill_valid, 0);
    chk("single_count0", bus.count, 0);
    chk("single_idle_busy", bus.busy, 0);

    // Merge of a secondary miss while WAIT is pending
    req0 = nreq;
    fill0 = nfill;
    bus.mem_req_ready = 1'b1;
    miss(32'h0000_0040);
    tick();
    bus.miss_valid = 1'b0;
    tick();
    chk("merge_req_addr", bus.mem_req_address, 32'h40);
    tick();
    bus.mem_req_ready = 1'b0;
    miss(32'h0000_005C);
    chk("merge_ready", bus.miss_ready, 1);
    chk("merge_merged", bus.miss_merged, MERGE);
    tick();
    bus.miss_valid = 1'b0;
    chk("merge_count", bus.count, MERGE ? 1 : 2);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = {8{32'h40}};
    tick();
    bus.mem_resp_valid = 1'b0;
    chk("merge_fill_addr", bus.fill_address, 32'h40);
    tick();
    chk("merge_count_after", bus.count, MERGE ? 0 : 1);
    chk("merge_refetch", bus.mem_req_valid, !MERGE);
`ifndef MRQ_MERGE_EN
    serve(32'h40);
    tick();
`endif
    chk("merge_drained", bus.count, 0);
    chk("merge_nreq", nreq - req0, MERGE ? 1 : 2);
    chk("merge_nfill", nfill - fill0, MERGE ? 1 : 2);

    // Full queue plus request hold with a spurious response in REQ
    for (int i = 0; i < DEPTH; i++) begin
      miss(32'((i + 1) * 256));
      chk("full_push_ready", bus.miss_ready, 1);
      tick();
    end
    miss(32'h0000_0500);
    chk("full_count", bus.count, DEPTH);
    chk("full_miss_ready", bus.miss_ready, 0);
    chk("full_miss_merged", bus.miss_merged, 0);
    bus.miss_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_req_valid", bus.mem_req_valid, 1);
      chk("hold_req_addr", bus.mem_req_address, 32'h100);
      chk("hold_no_fill", bus.fill_valid, 0);
      bus.mem_resp_valid = (i == 2);
      tick();
      bus.mem_resp_valid = 1'b0;
    end
    chk("hold_fill_after", bus.fill_valid, 0);
    chk("hold_count", bus.count, DEPTH);
    for (int i = 0; i < DEPTH; i++) serve(32'((i + 1) * 256));
    tick();
    chk("full_drained", bus.count, 0);

    // Wrap: the next DEPTH misses across the pointer boundary
    for (int i = 0; i < DEPTH; i++) begin
      miss(32'((i + 6) * 256));
      chk("wrap_push_ready", bus.miss_ready, 1);
      tick();
    end
    bus.miss_valid = 1'b0;
    chk("wrap_count", bus.count, DEPTH);
    for (int i = 0; i < DEPTH; i++) serve(32'((i + 6) * 256));
    tick();
    chk("wrap_drained", bus.count, 0);

    // Same-block miss during FILL allocates and refetches
    miss(32'h0000_0A00);
    tick();
    bus.miss_valid = 1'b0;
    serve(32'h0000_0A00);
    miss(32'h0000_0A04);
    chk("fillmiss_ready", bus.miss_ready, 1);
    chk("fillmiss_merged", bus.miss_merged, 0);
    tick();
    bus.miss_valid = 1'b0;
    chk("fillmiss_count", bus.count, 1);
    chk("fillmiss_req", bus.mem_req_valid, 1);
    chk("fillmiss_addr", bus.mem_req_address, 32'h0000_0A00);
    serve(32'h0000_0A00);
    tick();
    chk("fillmiss_drained", bus.count, 0);

    // Reset while WAIT is pending; a late response must be dropped
    miss(32'h0000_0B00);
    tick();
    bus.miss_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 20 && bus.mem_req_valid !== 1'b1; i++) tick();
    tick();
    bus.mem_req_ready = 1'b0;
    chk("wait_req_low", bus.mem_req_valid, 0);
    chk("wait_count", bus.count, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_count", bus.count, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_req_valid", bus.mem_req_valid, 0);
    chk("mrst_req_addr", bus.mem_req_address, 0);
    chk("mrst_fill_valid", bus.fill_valid, 0);
    chk("mrst_fill_addr", bus.fill_address, 0);
    chk("mrst_fill_data", bus.fill_data, 0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = {8{32'hDEAD_BEEF}};
    tick();
    bus.mem_resp_valid = 1'b0;
    chk("late_resp_fill", bus.fill_valid, 0);
    tick();
    chk("late_resp_fill2", bus.fill_valid, 0);
    chk("late_resp_req", bus.mem_req_valid, 0);
    chk("late_resp_count", bus.count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/miss_request_queue.md
# miss_request_queue

Non-blocking data cache miss tracker that sits directly upstream of the wait buffer. It records outstanding block misses, issues one block fetch at a time to the memory side, and emits a one-cycle fill pulse. The cache uses that pulse to write the block and to drive the wait buffer's `search_invalidate`/`search_address` walk. Secondary misses to a block that is already pending can be merged, so each block is fetched only once.

## Interface
- `ADDR_BITS`, 32, address width.
- `BLOCK_ID_START`, 5, first bit of the block ID; bits below it are the block offset.
- `BLOCK_WIDTH`, 256, fill data width in bits.
- `DEPTH`, 4, number of queue entries; a power of two, at least 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. Reset is synchronous and active-high: one clock; sampled on `posedge clk`.
- `miss_valid`  in  1  cache miss present this cycle.
- `miss_address`  in  ADDR_BITS  missing address; offset bits are ignored.
- `miss_ready`  out  1  the miss is accepted (allocated or merged) this cycle.
- `miss_merged`  out  1  the accepted miss hit a pending entry; no allocation.
- `mem_req_valid`  out  1  block fetch request.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_address`  out  ADDR_BITS  block-aligned address; offset bits are 0.
- `mem_resp_valid`  in  1  fill data returned.
- `mem_resp_data`  in  BLOCK_WIDTH  block data.
- `fill_valid`  out  1  one-cycle fill pulse.
- `fill_address`  out  ADDR_BITS  block-aligned address of the fill.
- `fill_data`  out  BLOCK_WIDTH  registered copy of `mem_resp_data`.
- `count`  out  $clog2(DEPTH+1)  number of occupied entries.
- `busy`  out  1  `count != 0`.

## Operation
- The queue is a circular FIFO of block IDs with `head`/`tail` pointers that wrap modulo DEPTH. Each entry has a valid bit.
- Comparisons use `miss_address[ADDR_BITS-1:BLOCK_ID_START]` only.
- Accept rule:
  - With merge compiled in, a block match against a mergeable entry gives `miss_ready=1`, `miss_merged=1`, and no state change.
  - Otherwise `miss_ready = miss_valid & (count != DEPTH)`; an accepted miss writes the tail entry and advances `tail`.
  - When full, a non-mergeable miss sees `miss_ready=0`, even if a pop occurs in the same cycle.
- Mergeable entries: every valid entry, except the head while the FSM is in FILL. A same-block miss in the FILL cycle allocates a new entry and triggers a harmless refetch.
- FSM states: IDLE, REQ, WAIT, FILL.
  - IDLE → REQ when `count != 0`.
  - REQ drives `mem_req_valid=1` with the head address. It moves to WAIT on `mem_req_valid & mem_req_ready`.
  - WAIT ignores `mem_req_ready`. On `mem_resp_valid` it captures `mem_resp_data` and the head address, then moves to FILL.
  - FILL drives `fill_valid=1` for exactly one cycle and pops the head (clear valid, advance `head`).
  - FILL → REQ if `count` after the pop is nonzero, else → IDLE.
- `mem_resp_valid` outside WAIT is ignored.
- Push and pop in the same cycle leave `count` unchanged.
- Only one request is outstanding at any time.

## Timing
- Reset values:
  - State IDLE; `head`=`tail`=0; all entry valids 0.
  - `count`=0, `busy`=0, `mem_req_valid`=0, `mem_req_address`=0.
  - `fill_valid`=0, `fill_address`=0, `fill_data`=0.
  - `miss_ready`/`miss_merged` are combinational and therefore 0 whenever `miss_valid`=0.
- `miss_ready`/`miss_merged` are combinational from `miss_valid`, `miss_address` and current state.
- Allocation becomes visible in `count` on the next cycle.
- Earliest issue: a miss accepted at cycle N in an empty queue gives IDLE at N+1 and `mem_req_valid=1` at N+2.
- `mem_req_valid` and `mem_req_address` are registered. They stay stable while `mem_req_valid & !mem_req_ready`.
- Fill latency: `mem_resp_valid` at cycle M gives `fill_valid=1` at M+1 with registered `fill_address`/`fill_data`.
- `count` decrements at M+2.
- Back-to-back: with a nonempty queue after FILL, `mem_req_valid` rises the cycle after FILL.
- Reset mid-operation: any outstanding request is abandoned. The memory side must also be reset; a late response is ignored because the FSM is IDLE.

## Configuration
- `MRQ_MERGE_EN` defined: secondary-miss merging is enabled as described above.
- `MRQ_MERGE_EN` undefined:
  - No comparators; `miss_merged` is tied to 0.
  - Every accepted miss allocates an entry, so duplicate blocks are fetched and filled separately, in order.

## Test plan
- Single miss: `miss_address`=0x0000_1234 into an empty queue with `mem_req_ready`=1.
  - `mem_req_address`=0x0000_1220 two cycles later.
  - Response 0xAA..AA gives `fill_valid` for exactly 1 cycle with `fill_address`=0x0000_1220; `count` returns to 0.
- Merge (`MRQ_MERGE_EN`): misses 0x40 then 0x5C while WAIT is pending.
  - Second miss gives `miss_merged`=1 with `count`=1.
  - Exactly one request and one fill.
  - Without the macro: two requests, two fills, `count` peaks at 2.
- Full: DEPTH distinct misses with `mem_req_ready`=0.
  - `count`=DEPTH, and miss DEPTH+1 (new block) sees `miss_ready`=0.
  - Raising `mem_req_ready` and responding drains the queue in FIFO order; `tail` wraps correctly on the next DEPTH misses.
- Handshake hold: `mem_req_ready`=0 for 5 cycles. `mem_req_valid` and `mem_req_address` stay stable; a spurious `mem_resp_valid` in REQ is ignored.
- FILL-cycle miss to the same block as the head: allocates (`miss_merged`=0), `count` unchanged that cycle, followed by a second request for that block.
- Reset asserted while in WAIT: next cycle all outputs are at reset values; a `mem_resp_valid` one cycle later produces no `fill_valid`.
